// File: rtl/dllp_retry_mgmt.sv
// dllp_retry_mgmt: tracks TLPs sent by tlp2dllp that the link partner has not yet
// acknowledged. It releases retry-buffer slots on ACK/NAK and requests a replay
// from tlp2dllp on NAK (or on replay-timer expiry when built with the
// DLLP_REPLAY_TIMER_EN macro). It pulses retrain_o when the replay counter rolls over.
//
// state  | meaning
// IDLE   | normal operation, pushes accepted, retry_index_o follows head_seq
// REPLAY | tlp2dllp is resending from the frozen retry_index_o; pushes ignored
module dllp_retry_mgmt #(
  parameter int RETRY_DEPTH    = 8,
  parameter int REPLAY_TIMEOUT = 711,
  parameter int REPLAY_NUM_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tlp_valid_i,
  input  logic [11:0] tlp_seq_i,
  input  logic        ack_valid_i,
  input  logic        ack_nak_i,
  input  logic [11:0] ack_seq_i,
  input  logic        replay_done_i,
  output logic        retry_available_o,
  output logic [7:0]  retry_index_o,
  output logic        full_o,
  output logic [8:0]  count_o,
  output logic        retrain_o,
  output logic        ack_err_o
);

  typedef enum logic [0:0] {IDLE, REPLAY} state_t;

  state_t      state_q, state_d;
  logic [11:0] head_q, head_d;
  logic [8:0]  count_q, count_d;
  logic [1:0]  rnum_q, rnum_d;
  logic [7:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic        retrain_q, retrain_d;

  logic [11:0] ack_n;
  logic        ack_dup, ack_in_range, rel, push_ok, push_err, ack_err;
  logic        nak_trig, timeout_trig, trigger;
  logic [8:0]  rel_n, count_rel;

`ifdef DLLP_REPLAY_TIMER_EN
  localparam int TW = $clog2(REPLAY_TIMEOUT + 1);
  logic [TW-1:0] timer_q;

  assign timeout_trig = (count_q != 9'd0) && (timer_q == TW'(REPLAY_TIMEOUT - 1));

  // Replay timer: runs only in IDLE with TLPs outstanding; any release, replay or empty buffer restarts it.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      timer_q <= '0;
    else if (state_q != IDLE || trigger || rel || count_q == 9'd0)
      timer_q <= '0;
    else
      timer_q <= timer_q + 1'b1;
  end
`else
  assign timeout_trig = 1'b0;
`endif

  // Ack/NAK decode and push qualification; all sequence arithmetic wraps at 4096.
  always_comb begin
    ack_n        = ack_seq_i - head_q + 12'd1;
    ack_dup      = (ack_n == 12'd0);
    ack_in_range = !ack_dup && (ack_n <= {3'b000, count_q});
    rel          = ack_valid_i && ack_in_range;
    rel_n        = rel ? ack_n[8:0] : 9'd0;
    count_rel    = count_q - rel_n;
    ack_err      = ack_valid_i && !ack_dup && !ack_in_range;
    push_ok      = tlp_valid_i && (state_q == IDLE) && !full_o &&
                   (tlp_seq_i == head_q + 12'(count_q));
    push_err     = tlp_valid_i && (state_q == IDLE) && !push_ok;
    nak_trig     = ack_valid_i && ack_nak_i && (ack_dup || ack_in_range) && (count_rel != 9'd0);
    trigger      = (state_q == IDLE) && (nak_trig || timeout_trig);
  end

  // Next-state logic: FSM, slot tracking, replay counter and pulse outputs.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q + 12'(rel_n);
    count_d   = count_rel + (push_ok ? 9'd1 : 9'd0);
    rnum_d    = rel ? 2'd0 : rnum_q;
    idx_d     = idx_q;
    err_d     = push_err || ack_err;
    retrain_d = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = 8'(head_d & 12'(RETRY_DEPTH - 1));
        if (trigger) begin
          state_d = REPLAY;
          if (32'(rnum_d) == REPLAY_NUM_MAX) begin
            rnum_d    = 2'd0;
            retrain_d = 1'b1;
          end else begin
            rnum_d = rnum_d + 2'd1;
          end
        end
      end
      REPLAY: begin
        if (replay_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and tracking registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      head_q    <= '0;
      count_q   <= '0;
      rnum_q    <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      retrain_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      count_q   <= count_d;
      rnum_q    <= rnum_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      retrain_q <= retrain_d;
    end
  end

  assign retry_available_o = (state_q == REPLAY);
  assign retry_index_o     = idx_q;
  assign count_o           = count_q;
  assign full_o            = (count_q == 9'(RETRY_DEPTH));
  assign retrain_o         = retrain_q;
  assign ack_err_o         = err_q;

endmodule

// File: tb/tb_dllp_retry_mgmt.sv
// Directed bench for dllp_retry_mgmt (RETRY_DEPTH 8, REPLAY_TIMEOUT 16).
// Inputs change on the falling edge; outputs are read on the following falling edge.
module tb_dllp_retry_mgmt;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tlp_valid = 1'b0;
  logic [11:0] tlp_seq = '0;
  logic        ack_valid = 1'b0;
  logic        ack_nak = 1'b0;
  logic [11:0] ack_seq = '0;
  logic        replay_done = 1'b0;
  logic        retry_available;
  logic [7:0]  retry_index;
  logic        full;
  logic [8:0]  count;
  logic        retrain;
  logic        ack_err;

  int checks = 0;
  int passed = 0;

  dllp_retry_mgmt #(.RETRY_DEPTH(8), .REPLAY_TIMEOUT(16), .REPLAY_NUM_MAX(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .tlp_valid_i(tlp_valid), .tlp_seq_i(tlp_seq),
    .ack_valid_i(ack_valid), .ack_nak_i(ack_nak), .ack_seq_i(ack_seq),
    .replay_done_i(replay_done),
    .retry_available_o(retry_available), .retry_index_o(retry_index),
    .full_o(full), .count_o(count), .retrain_o(retrain), .ack_err_o(ack_err)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic push(input logic [11:0] s);
    tlp_valid = 1'b1; tlp_seq = s;
    @(negedge clk); tlp_valid = 1'b0;
  endtask

  task automatic ack(input logic [11:0] s, input logic nak);
    ack_valid = 1'b1; ack_seq = s; ack_nak = nak;
    @(negedge clk); ack_valid = 1'b0; ack_nak = 1'b0;
  endtask

  task automatic push_ack(input logic [11:0] s, input logic [11:0] a);
    tlp_valid = 1'b1; tlp_seq = s; ack_valid = 1'b1; ack_seq = a; ack_nak = 1'b0;
    @(negedge clk); tlp_valid = 1'b0; ack_valid = 1'b0;
  endtask

  task automatic done();
    replay_done = 1'b1;
    @(negedge clk); replay_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 9'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else passed++;
    checks++; if (retry_available !== 1'b0) $display("FAIL reset_retry got %b want 0", retry_available); else passed++;
    checks++; if (retry_index !== 8'd0) $display("FAIL reset_index got %0d want 0", retry_index); else passed++;
    checks++; if (retrain !== 1'b0) $display("FAIL reset_retrain got %b want 0", retrain); else passed++;
    checks++; if (ack_err !== 1'b0) $display("FAIL reset_ack_err got %b want 0", ack_err); else passed++;
  endtask

  task automatic test_ack();
    do_reset();
    for (int i = 0; i < 4; i++) push(12'(i));
    checks++; if (count !== 9'd4) $display("FAIL ack_pre_count got %0d want 4", count); else passed++;
    ack(12'd1, 1'b0);
    checks++; if (count !== 9'd2) $display("FAIL ack_count got %0d want 2", count); else passed++;
    checks++; if (retry_index !== 8'd2) $display("FAIL ack_index got %0d want 2", retry_index); else passed++;
    checks++; if (retry_available !== 1'b0) $display("FAIL ack_retry got %b want 0", retry_available); else passed++;
    checks++; if (ack_err !== 1'b0) $display("FAIL ack_err got %b want 0", ack_err); else passed++;
  endtask

  task automatic test_nak();
    do_reset();
    for (int i = 0; i < 4; i++) push(12'(i));
    ack(12'd0, 1'b1);
    checks++; if (count !== 9'd3) $display("FAIL nak_count got %0d want 3", count); else passed++;
    checks++; if (retry_available !== 1'b1) $display("FAIL nak_retry got %b want 1", retry_available); else passed++;
    checks++; if (retry_index !== 8'd1) $display("FAIL nak_index got %0d want 1", retry_index); else passed++;
    push(12'd4);
    checks++; if (count !== 9'd3) $display("FAIL replay_push_count got %0d want 3", count); else passed++;
    checks++; if (ack_err !== 1'b0) $display("FAIL replay_push_err got %b want 0", ack_err); else passed++;
    ack(12'd1, 1'b0);
    checks++; if (count !== 9'd2) $display("FAIL replay_ack_count got %0d want 2", count); else passed++;
    checks++; if (retry_index !== 8'd1) $display("FAIL replay_frozen_index got %0d want 1", retry_index); else passed++;
    done();
    checks++; if (retry_available !== 1'b0) $display("FAIL done_retry got %b want 0", retry_available); else passed++;
    @(negedge clk);
    checks++; if (retry_index !== 8'd2) $display("FAIL post_replay_index got %0d want 2", retry_index); else passed++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) push(12'(i));
    checks++; if (full !== 1'b1) $display("FAIL full_flag got %b want 1", full); else passed++;
    push(12'd8);
    checks++; if (ack_err !== 1'b1) $display("FAIL full_push_err got %b want 1", ack_err); else passed++;
    checks++; if (count !== 9'd8) $display("FAIL full_push_count got %0d want 8", count); else passed++;
    @(negedge clk);
    checks++; if (ack_err !== 1'b0) $display("FAIL full_err_pulse got %b want 0", ack_err); else passed++;
  endtask

  task automatic test_retrain();
    do_reset();
    push(12'd0); push(12'd1);
    for (int i = 0; i < 4; i++) begin
      ack(12'd0, 1'b1);
      checks++; if (retry_available !== 1'b1) $display("FAIL retrain_retry[%0d] got %b want 1", i, retry_available); else passed++;
      checks++; if (retrain !== (i == 3)) $display("FAIL retrain_pulse[%0d] got %b want %b", i, retrain, (i == 3)); else passed++;
      done();
    end
    checks++; if (count !== 9'd1) $display("FAIL retrain_count got %0d want 1", count); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int s = 0; s < 4094; s++) begin
      push(12'(s));
      ack(12'(s), 1'b0);
    end
    push(12'd4094); push(12'd4095); push(12'd0);
    checks++; if (count !== 9'd3) $display("FAIL wrap_pre_count got %0d want 3", count); else passed++;
    ack(12'd0, 1'b0);
    checks++; if (count !== 9'd0) $display("FAIL wrap_count got %0d want 0", count); else passed++;
    checks++; if (ack_err !== 1'b0) $display("FAIL wrap_err got %b want 0", ack_err); else passed++;
    checks++; if (retry_index !== 8'd1) $display("FAIL wrap_index got %0d want 1", retry_index); else passed++;
    ack(12'd2000, 1'b0);
    checks++; if (ack_err !== 1'b1) $display("FAIL range_err got %b want 1", ack_err); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(12'd0); push(12'd1);
    push_ack(12'd2, 12'd0);
    checks++; if (count !== 9'd2) $display("FAIL b2b_count got %0d want 2", count); else passed++;
    checks++; if (retry_index !== 8'd1) $display("FAIL b2b_index got %0d want 1", retry_index); else passed++;
    push(12'd5);
    checks++; if (ack_err !== 1'b1) $display("FAIL bad_seq_err got %b want 1", ack_err); else passed++;
    checks++; if (count !== 9'd2) $display("FAIL bad_seq_count got %0d want 2", count); else passed++;
    ack(12'd0, 1'b0);
    checks++; if (ack_err !== 1'b0) $display("FAIL dup_ack_err got %b want 0", ack_err); else passed++;
    checks++; if (count !== 9'd2) $display("FAIL dup_ack_count got %0d want 2", count); else passed++;
    ack(12'd2, 1'b1);
    checks++; if (count !== 9'd0) $display("FAIL nak_empty_count got %0d want 0", count); else passed++;
    checks++; if (retry_available !== 1'b0) $display("FAIL nak_empty_retry got %b want 0", retry_available); else passed++;
  endtask

  task automatic test_timer();
    do_reset();
    push(12'd0);
    repeat (15) @(negedge clk);
    checks++; if (retry_available !== 1'b0) $display("FAIL timer_early got %b want 0", retry_available); else passed++;
    @(negedge clk);
`ifdef DLLP_REPLAY_TIMER_EN
    checks++; if (retry_available !== 1'b1) $display("FAIL timer_expiry got %b want 1", retry_available); else passed++;
    checks++; if (retry_index !== 8'd0) $display("FAIL timer_index got %0d want 0", retry_index); else passed++;
`else
    repeat (30) @(negedge clk);
    checks++; if (retry_available !== 1'b0) $display("FAIL no_timer_retry got %b want 0", retry_available); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_ack();
    test_nak();
    test_full();
    test_retrain();
    test_wrap();
    test_back_to_back();
    test_timer();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
